// File: rtl/step_count_fsm.sv
// step_count_fsm: up/down index counter with divider, load, wrap/saturate modes.
// Count is the registered index scaled by STEP.
module step_count_fsm #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 4,
  parameter int STEP     = 2,
  parameter int DIV_BITS = 26,
  parameter int IDX_W    = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Enable,
  input  logic             Count_up,
  input  logic             Sat_mode,
  input  logic             Load,
  input  logic [IDX_W-1:0] Load_idx,
  input  logic             Ext_tick,
  output logic [WIDTH-1:0] Count,
  output logic             Tick,
  output logic             Wrap,
  output logic             Saturated
);
  localparam logic [1:0] IDLE = 2'd0, COUNT = 2'd1, SAT = 2'd2;
  localparam logic [IDX_W-1:0] TOP = IDX_W'(MODULUS - 1);
  localparam logic [IDX_W-1:0] ONE = IDX_W'(1);
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
  logic [1:0] state, state_n;
  logic [IDX_W-1:0] idx, idx_n, stepped;
  logic tick_c, wrap_n, at_top, at_bot, end_hit, inward;
  generate
    if (DIV_BITS > 0) begin : g_div
      logic [DIV_BITS-1:0] div;
      logic unused_ext;
      assign unused_ext = Ext_tick;
      assign tick_c = &div;
      always_ff @(posedge Clk or posedge Reset)
        if (Reset) div <= '0;
        else div <= Load ? '0 : div + DIV_BITS'(1);
    end else begin : g_ext
      assign tick_c = Ext_tick;
    end
  endgenerate
  assign at_top  = idx == TOP;
  assign at_bot  = idx == '0;
  assign end_hit = Count_up ? at_top : at_bot;
  assign inward  = Count_up ? at_bot : at_top;
  assign stepped = Count_up ? (at_top ? '0 : idx + ONE) : (at_bot ? TOP : idx - ONE);
  always_comb begin
    idx_n   = idx;
    state_n = state;
    wrap_n  = 1'b0;
    if (Load) begin
      idx_n   = (Load_idx > TOP) ? TOP : Load_idx;
      state_n = Enable ? COUNT : IDLE;
    end else if (!Enable) begin
      state_n = IDLE;
    end else if (state == IDLE) begin
      state_n = COUNT;
    end else if (state == COUNT) begin
      if (tick_c && end_hit && Sat_mode) state_n = SAT;
      else if (tick_c) begin
        idx_n  = stepped;
        wrap_n = end_hit;
      end
    end else if (state == SAT) begin
      // leaving SAT by a mode change does not step; an inward tick does
      if (!Sat_mode) state_n = COUNT;
      else if (tick_c && inward) begin
        idx_n   = stepped;
        state_n = COUNT;
      end
    end else begin
      idx_n   = '0;
      state_n = IDLE;
    end
  end
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state <= IDLE;
      idx   <= '0;
      Count <= '0;
      Tick  <= 1'b0;
      Wrap  <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      Count <= WIDTH'(idx_n) * STEP_W;
      Tick  <= tick_c;
      Wrap  <= wrap_n;
    end
  assign Saturated = state == SAT;
endmodule

// File: tb/tb_step_count_fsm.sv
// tb_step_count_fsm: three DUT variants under directed and random stimulus,
// checked each cycle against a behavioural index/mode model.
module tb_step_count_fsm;
  logic clk = 1'b0, rst = 1'b0, en = 1'b0, up = 1'b1, sat = 1'b0, load = 1'b0, ext = 1'b0;
  logic [1:0] lidx = '0;
  logic [3:0] cnt [3];
  logic tk [3], wr [3], st [3];
  logic chk_on = 1'b0;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  step_count_fsm #(.WIDTH(4), .MODULUS(4), .STEP(2), .DIV_BITS(2), .IDX_W(2)) d0 (
    .Clk(clk), .Reset(rst), .Enable(en), .Count_up(up), .Sat_mode(sat), .Load(load),
    .Load_idx(lidx), .Ext_tick(ext), .Count(cnt[0]), .Tick(tk[0]), .Wrap(wr[0]), .Saturated(st[0]));
  step_count_fsm #(.WIDTH(4), .MODULUS(3), .STEP(3), .DIV_BITS(2), .IDX_W(2)) d1 (
    .Clk(clk), .Reset(rst), .Enable(en), .Count_up(up), .Sat_mode(sat), .Load(load),
    .Load_idx(lidx), .Ext_tick(ext), .Count(cnt[1]), .Tick(tk[1]), .Wrap(wr[1]), .Saturated(st[1]));
  step_count_fsm #(.WIDTH(4), .MODULUS(4), .STEP(2), .DIV_BITS(0), .IDX_W(2)) d2 (
    .Clk(clk), .Reset(rst), .Enable(en), .Count_up(up), .Sat_mode(sat), .Load(load),
    .Load_idx(lidx), .Ext_tick(ext), .Count(cnt[2]), .Tick(tk[2]), .Wrap(wr[2]), .Saturated(st[2]));
  typedef struct {int idx; bit act; bit sat; int div; bit wrap; bit tick;} mdl_t;
  mdl_t m [3];
  function automatic int md(int i); return i == 1 ? 3 : 4; endfunction
  function automatic int sp(int i); return i == 1 ? 3 : 2; endfunction
  function automatic int db(int i); return i == 2 ? 0 : 2; endfunction
  function automatic mdl_t mzero();
    mdl_t z;
    z.idx = 0; z.act = 0; z.sat = 0; z.div = 0; z.wrap = 0; z.tick = 0;
    return z;
  endfunction
  function automatic mdl_t mstep(mdl_t c, int mo, int dbits);
    mdl_t n = c;
    bit tc;
    int t;
    tc = (dbits == 0) ? ext : (c.div == (1 << dbits) - 1);
    n.tick = tc;
    n.wrap = 0;
    n.div = (dbits == 0) ? 0 : (c.div + 1) % (1 << dbits);
    if (load) begin
      n.idx = (int'(lidx) > mo - 1) ? mo - 1 : int'(lidx);
      n.div = 0; n.act = en; n.sat = 0;
    end else if (!en) begin
      n.act = 0; n.sat = 0;
    end else if (!c.act) begin
      n.act = 1;
    end else if (c.sat) begin
      if (!sat) n.sat = 0;
      else if (tc && ((c.idx == 0 && up) || (c.idx == mo - 1 && !up))) begin
        n.idx = c.idx + (up ? 1 : -1); n.sat = 0;
      end
    end else if (tc) begin
      t = c.idx + (up ? 1 : -1);
      if (t >= 0 && t < mo) n.idx = t;
      else if (sat) n.sat = 1;
      else begin n.idx = (t + mo) % mo; n.wrap = 1; end
    end
    return n;
  endfunction
  always @(posedge clk or posedge rst)
    for (int i = 0; i < 3; i++) m[i] <= rst ? mzero() : mstep(m[i], md(i), db(i));
  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%0h want=%0h t=%0t", nm, i, act, exp, $time);
    end
  endtask
  always @(negedge clk)
    if (chk_on && !rst)
      for (int i = 0; i < 3; i++) begin
        chk("count", i, 32'(cnt[i]), 32'(m[i].idx * sp(i)));
        chk("tick", i, 32'(tk[i]), 32'(m[i].tick));
        chk("wrap", i, 32'(wr[i]), 32'(m[i].wrap));
        chk("saturated", i, 32'(st[i]), 32'(m[i].sat));
      end
  int gap;
  task automatic wait_tick();
    gap = 0;
    do begin @(negedge clk); gap++; end while (!tk[0] && gap < 20);
    if (!tk[0]) chk("tick_timeout", 0, 0, 1);
  endtask
  initial begin
    int up_e [5] = '{2, 4, 6, 0, 2};
    int dn_e [5] = '{0, 6, 4, 2, 0};
    int sat_e [4] = '{2, 4, 6, 6};
    int ntk, held;
    #1 rst = 1'b1;
    #12 rst = 1'b0;
    chk("lit_reset_count", 0, 32'(cnt[0]), 0);
    chk("lit_reset_sat", 0, 32'(st[0]), 0);
    chk_on = 1'b1;
    en = 1'b1; up = 1'b1; sat = 1'b0;
    for (int k = 0; k < 5; k++) begin
      wait_tick();
      chk("lit_up_count", 0, 32'(cnt[0]), 32'(up_e[k]));
      chk("lit_up_wrap", 0, 32'(wr[0]), 32'(up_e[k] == 0));
      if (k > 0) chk("lit_tick_period", 0, 32'(gap), 4);
    end
    up = 1'b0;
    for (int k = 0; k < 5; k++) begin
      wait_tick();
      chk("lit_dn_count", 0, 32'(cnt[0]), 32'(dn_e[k]));
      chk("lit_dn_wrap", 0, 32'(wr[0]), 32'(dn_e[k] == 6));
    end
    up = 1'b1; sat = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_tick();
      chk("lit_sat_count", 0, 32'(cnt[0]), 32'(sat_e[k]));
      chk("lit_sat_flag", 0, 32'(st[0]), 32'(k == 3));
    end
    up = 1'b0;
    wait_tick();
    chk("lit_unsat_count", 0, 32'(cnt[0]), 4);
    chk("lit_unsat_flag", 0, 32'(st[0]), 0);
    chk("lit_unsat_wrap", 0, 32'(wr[0]), 0);
    repeat (3) @(negedge clk);
    load = 1'b1; lidx = 2'd2;
    @(negedge clk);
    load = 1'b0;
    chk("lit_load_count", 0, 32'(cnt[0]), 4);
    repeat (3) begin
      @(negedge clk);
      chk("lit_load_hold", 0, 32'(cnt[0]), 4);
    end
    @(negedge clk);
    chk("lit_load_step", 0, 32'(cnt[0]), 2);
    load = 1'b1; lidx = 2'd3;
    @(negedge clk);
    load = 1'b0;
    chk("lit_load3", 0, 32'(cnt[0]), 6);
    chk("lit_clamp", 1, 32'(cnt[1]), 6);
    en = 1'b0; ntk = 0; held = int'(cnt[0]);
    repeat (12) begin
      @(negedge clk);
      chk("lit_hold", 0, 32'(cnt[0]), 32'(held));
      if (tk[0]) ntk++;
    end
    chk("lit_hold_ticks", 0, 32'(ntk), 3);
    en = 1'b1; up = 1'b1; sat = 1'b1;
    wait_tick();
    wait_tick();
    chk("lit_presat_count", 0, 32'(cnt[0]), 6);
    chk("lit_presat_flag", 0, 32'(st[0]), 1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("lit_async_count", 0, 32'(cnt[0]), 0);
    chk("lit_async_sat", 0, 32'(st[0]), 0);
    chk("lit_async_tick", 0, 32'(tk[0]), 0);
    #3 rst = 1'b0;
    gap = 0;
    do begin @(negedge clk); gap++; end while (cnt[0] == 4'd0 && gap < 20);
    chk("lit_first_step", 0, 32'(gap), 4);
    sat = 1'b0; load = 1'b1; lidx = 2'd0;
    @(negedge clk);
    load = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      ext = 1'b1;
      @(negedge clk);
      ext = 1'b0;
      @(negedge clk);
      chk("lit_ext_step", 2, 32'(cnt[2]), 32'(2 * k));
    end
    repeat (3000) begin
      @(negedge clk);
      en = ($urandom % 8) != 0;
      if ($urandom % 10 == 0) up = ~up;
      if ($urandom % 12 == 0) sat = ~sat;
      load = ($urandom % 16) == 0;
      lidx = 2'($urandom % 4);
      ext = ($urandom % 3) == 0;
      if ($urandom % 200 == 0) begin
        #2 rst = 1'b1;
        #1 rst = 1'b0;
      end
    end
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/step_count_fsm.md
Name: step_count_fsm

Overview:
- Parametrised successor to the team's fixed 4-state, step-2 up/down count FSM.
- Steps an index through MODULUS states and outputs Count = index × STEP.
- Advances once per internal divider tick, or per external tick when the divider is bypassed. The divider is a synchronous enable in the Clk domain, not a derived clock.
- Adds enable/hold, synchronous load, wrap-vs-saturate mode and wrap/saturation status.
- Drives board LEDs/7-seg counters in lab top levels.

Parameters:
- WIDTH, 4: width of Count. Elaboration must satisfy (MODULUS-1)*STEP < 2^WIDTH.
- MODULUS, 4: number of index states, ≥2.
- STEP, 2: Count increment per index.
- DIV_BITS, 26: divider width. Tick period is 2^DIV_BITS Clk cycles. 0 means no divider: Ext_tick is used directly.
- IDX_W, 2: index width, ≥ clog2(MODULUS).

Ports:
- Clk, in, 1: clock.
- Reset, in, 1: asynchronous, active-high.
- Enable, in, 1: 1 = count on ticks; 0 = hold.
- Count_up, in, 1: 1 = increment index, 0 = decrement.
- Sat_mode, in, 1: 1 = saturate at ends, 0 = wrap.
- Load, in, 1: synchronous load strobe.
- Load_idx, in, IDX_W: index to load.
- Ext_tick, in, 1: step strobe, used only when DIV_BITS=0.
- Count, out, WIDTH: registered, = idx*STEP.
- Tick, out, 1: registered one-cycle pulse when a step opportunity occurs.
- Wrap, out, 1: one-cycle pulse on a wrap step.
- Saturated, out, 1: level; high while in state SAT.

Behaviour:
- Reset (async, any time, including mid-divide): div=0, idx=0, state=IDLE, Count=0, Tick=0, Wrap=0, Saturated=0.
- Divider:
  - div increments every Clk, free-running.
  - tick_c = (div == all-ones), i.e. one cycle in 2^DIV_BITS.
  - DIV_BITS=0: tick_c = Ext_tick.
  - Tick register = tick_c delayed one cycle.
  - Load clears div to 0.
- Control FSM (state register, async reset):
  - IDLE: Enable=0; idx frozen. Enable=1 → COUNT.
  - COUNT: on tick_c, step idx. If Sat_mode=1 and the step would cross an end, hold idx and → SAT. Enable=0 → IDLE.
  - SAT: idx held at 0 or MODULUS-1. Exit → COUNT on a tick_c whose direction points inward, performing that step in the same cycle. Also exit → COUNT on Sat_mode=0 (no step that cycle). Enable=0 → IDLE.
- Stepping rules (COUNT, tick_c=1):
  - Up: idx<MODULUS-1 → idx+1. At MODULUS-1: wrap mode → 0 with Wrap=1 next cycle; saturate mode → hold, go to SAT.
  - Down: idx>0 → idx-1. At 0: wrap mode → MODULUS-1 with Wrap=1; saturate mode → hold, go to SAT.
- Load (highest priority, any state except reset):
  - Next edge: idx = min(Load_idx, MODULUS-1), div=0, Wrap=0.
  - State becomes COUNT if Enable=1, else IDLE. SAT is cleared.
  - A tick_c coinciding with Load is ignored.
- Count is registered: Count updates on the same edge as idx, so latency from the tick_c cycle is 1 Clk.
  - Count = idx*STEP, computed at WIDTH bits, no truncation given the elaboration constraint.
- Priority per edge: Reset > Load > Enable=0 (hold) > tick step. Count_up and Sat_mode are sampled only on tick_c edges, except the Sat_mode exit from SAT.
- Wrap is a single-cycle pulse; it is never asserted in saturate mode or on Load.
- Saturated = (state==SAT), registered.
- Out-of-range idx is unreachable. Defaults (no-match) map to idx=0, state=IDLE.

Test Plan:
All scenarios use WIDTH=4, MODULUS=4, STEP=2, DIV_BITS=2 (tick every 4 Clk) unless stated.

1. Reset, Enable=1, Count_up=1, Sat_mode=0 for 20 ticks → Count 0,2,4,6,0,… changing one Clk after each tick_c. Wrap pulses once per 6→0 transition. Tick period is 4 Clk.
2. Count_up=0 from Count=0, wrap mode → 6,4,2,0,6. Wrap pulses on each 0→6.
3. Sat_mode=1, up from 0 → 2,4,6,6,6; Saturated=1 from the tick after 6 is reached. Then Count_up=0 → next tick gives Count=4, Saturated=0, no Wrap.
4. Load=1 with Load_idx=2 coinciding with tick_c → Count=4 next edge, div=0; the next step occurs 4 Clk later. Load_idx=3 → Count=6. With MODULUS=3, STEP=3, Load_idx=3 → clamped, Count=6.
5. Enable=0 mid-count for 12 Clk → Count frozen, Tick still pulses, state IDLE. Re-enable → counting resumes from the held value.
6. Assert Reset asynchronously mid-divide with Count=6 and Saturated=1 → all outputs 0 immediately, with no Clk edge required. Release → first step occurs after 4 Clk. Also run DIV_BITS=0 with Ext_tick pulses → one step per pulse.
